// File: rtl/gmii_tx_arbiter.sv
// Round-robin GMII transmit scheduler for two MAC-side frame sources.
// Adds preamble/SFD, forwards payload, aborts on underrun/oversize and enforces the inter-packet gap.
module gmii_tx_arbiter #(
  parameter int PREAMBLE_LEN = 7,
  parameter int IPG_LEN      = 12,
  parameter int MAX_FRAME    = 1518
) (
  input  logic       GTX_CLK,
  input  logic       RESET,
  input  logic       req_a,
  input  logic [7:0] data_a,
  input  logic       valid_a,
  input  logic       last_a,
  output logic       ready_a,
  output logic       grant_a,
  input  logic       req_b,
  input  logic [7:0] data_b,
  input  logic       valid_b,
  input  logic       last_b,
  output logic       ready_b,
  output logic       grant_b,
  output logic       TX_EN,
  output logic       TX_ER,
  output logic [7:0] tx_octet,
  output logic       busy,
  output logic [2:0] dbg_state
);

  localparam int CW   = $clog2(MAX_FRAME + 1);
  localparam int TMAX = (PREAMBLE_LEN > IPG_LEN) ? PREAMBLE_LEN : IPG_LEN;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_SFD      = 3'd2,
    S_DATA     = 3'd3,
    S_ERR      = 3'd4,
    S_IPG      = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic            tx_en_q, tx_en_d;
  logic            tx_er_q, tx_er_d;
  logic [7:0]      tx_octet_q, tx_octet_d;
  logic            grant_a_q, grant_a_d;
  logic            grant_b_q, grant_b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            prio_b_q, prio_b_d;

  logic            accept_phase;
  logic [7:0]      sel_data;
  logic            sel_valid;
  logic            sel_last;
  logic            win_b;
  logic            enter_ipg;
  logic [TW-1:0]   low_seen;

  // Handshake: an octet moves when ready_x and valid_x are both high at a rising edge;
  // ready_x depends only on registered state, never on valid_x.
  assign accept_phase = (state_q == S_SFD) || (state_q == S_DATA);
  assign ready_a      = grant_a_q & accept_phase;
  assign ready_b      = grant_b_q & accept_phase;

  assign sel_data  = grant_a_q ? data_a  : data_b;
  assign sel_valid = grant_a_q ? valid_a : valid_b;
  assign sel_last  = grant_a_q ? last_a  : last_b;

  // The low-cycle count only advances on cycles where TX_EN is already low, so the gap is the same
  // whether IPG is entered behind the last payload octet or behind the error cycle.
  assign low_seen = tmr_q + (tx_en_q ? TW'(0) : TW'(1));

  always_comb begin
    state_d    = state_q;
    tx_en_d    = tx_en_q;
    tx_er_d    = tx_er_q;
    tx_octet_d = tx_octet_q;
    grant_a_d  = grant_a_q;
    grant_b_d  = grant_b_q;
    cnt_d      = cnt_q;
    tmr_d      = tmr_q;
    prio_b_d   = prio_b_q;
    win_b      = 1'b0;
    enter_ipg  = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_en_d    = 1'b0;
        tx_er_d    = 1'b0;
        tx_octet_d = 8'h00;
        if (req_a || req_b) begin
          win_b      = req_b && (!req_a || prio_b_q);
          grant_a_d  = !win_b;
          grant_b_d  = win_b;
          tx_en_d    = 1'b1;
          tx_octet_d = 8'h55;
          tmr_d      = TW'(1);
          state_d    = S_PREAMBLE;
        end
      end
      S_PREAMBLE: begin
        if (tmr_q == TW'(PREAMBLE_LEN)) begin
          tx_octet_d = 8'hD5;
          tmr_d      = '0;
          state_d    = S_SFD;
        end else begin
          tx_octet_d = 8'h55;
          tmr_d      = tmr_q + TW'(1);
        end
      end
      S_SFD, S_DATA: begin
        if (sel_valid) begin
          tx_en_d    = 1'b1;
          tx_octet_d = sel_data;
          cnt_d      = cnt_q + CW'(1);
          if (sel_last) begin
            enter_ipg = 1'b1;
          end else if (cnt_q == CW'(MAX_FRAME - 1)) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          tx_en_d    = 1'b1;
          tx_er_d    = 1'b1;
          tx_octet_d = 8'h00;
          state_d    = S_ERR;
        end
      end
      S_ERR: begin
        // After an oversize octet the error symbol is still pending; after an underrun it is already on the wire.
        if (tx_er_q) begin
          tx_en_d    = 1'b0;
          tx_er_d    = 1'b0;
          tx_octet_d = 8'h00;
          enter_ipg  = 1'b1;
        end else begin
          tx_en_d    = 1'b1;
          tx_er_d    = 1'b1;
          tx_octet_d = 8'h00;
        end
      end
      S_IPG: begin
        tx_en_d    = 1'b0;
        tx_er_d    = 1'b0;
        tx_octet_d = 8'h00;
        if (low_seen == TW'(IPG_LEN - 1)) begin
          tmr_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmr_d = low_seen;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_ipg) begin
      state_d   = S_IPG;
      grant_a_d = 1'b0;
      grant_b_d = 1'b0;
      cnt_d     = '0;
      tmr_d     = '0;
      prio_b_d  = grant_a_q;
    end
  end

  always_ff @(posedge GTX_CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      tx_en_q    <= 1'b0;
      tx_er_q    <= 1'b0;
      tx_octet_q <= 8'h00;
      grant_a_q  <= 1'b0;
      grant_b_q  <= 1'b0;
      cnt_q      <= '0;
      tmr_q      <= '0;
      prio_b_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_en_q    <= tx_en_d;
      tx_er_q    <= tx_er_d;
      tx_octet_q <= tx_octet_d;
      grant_a_q  <= grant_a_d;
      grant_b_q  <= grant_b_d;
      cnt_q      <= cnt_d;
      tmr_q      <= tmr_d;
      prio_b_q   <= prio_b_d;
    end
  end

  assign TX_EN     = tx_en_q;
  assign TX_ER     = tx_er_q;
  assign tx_octet  = tx_octet_q;
  assign grant_a   = grant_a_q;
  assign grant_b   = grant_b_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: doc/gmii_tx_arbiter.md
Name: gmii_tx_arbiter

Overview:
- Transmit-side scheduler sharing one GMII transmit path (TX_EN, TX_ER, tx_octet feeding the PCS transmit/encoder) between two MAC-side frame sources, A and B.
- Arbitrates round-robin, prepends preamble and SFD, forwards payload octets, and enforces the inter-packet gap.
- Aborts a frame with an error cycle on source underrun or oversize.

Parameters:
- PREAMBLE_LEN, 7: number of 0x55 octets before the SFD (legal range 1 or more).
- IPG_LEN, 12: minimum TX_EN-low cycles between frames (legal range 2 or more).
- MAX_FRAME, 1518: maximum payload octets per frame. The counter is $clog2(MAX_FRAME+1) bits wide.

Ports:
- GTX_CLK  in  1  sole clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- req_a  in  1  source A has a frame pending.
- data_a  in  8  source A payload octet.
- valid_a  in  1  data_a is valid.
- last_a  in  1  data_a is the final octet of the frame.
- ready_a  out  1  arbiter accepts data_a this cycle.
- grant_a  out  1  source A owns the transmit path.
- req_b, data_b, valid_b, last_b, ready_b, grant_b: same as for A.
- TX_EN  out  1  GMII transmit enable.
- TX_ER  out  1  GMII transmit error.
- tx_octet  out  8  GMII transmit data.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Clock and reset: one clock domain, GTX_CLK. RESET is synchronous and active-high.
- Registered outputs: TX_EN, TX_ER, tx_octet, grant_a, grant_b and the state are registered. ready_x is combinational: grant_x AND (state==SFD OR state==DATA).
- Reset values: TX_EN=0, TX_ER=0, tx_octet=0x00, grant_a=0, grant_b=0, busy=0, state=IDLE, octet counter=0, round-robin pointer=favour A.
- Reset mid-operation: the edge with RESET=1 forces the reset values regardless of state. The in-flight frame is abandoned and no TX_ER is raised.
- States: IDLE, PREAMBLE, SFD, DATA, ERR, IPG.
- IDLE: TX_EN=0, tx_octet=0x00.
  - On an edge with req_a or req_b high, the winner is chosen and the state moves to PREAMBLE.
  - On that same edge: grant_winner<=1, TX_EN<=1, tx_octet<=0x55.
  - Both requests high: the source not served last wins. After reset, A wins.
  - This IDLE cycle counts as one gap cycle.
- PREAMBLE: outputs 0x55 for PREAMBLE_LEN cycles total, then goes to SFD with tx_octet<=0xD5.
- SFD/DATA, with ready high:
  - Accept on valid: the edge outputs tx_octet<=data, TX_EN<=1, and increments the counter. Latency from acceptance edge to output is 0 cycles (registered on the accepting edge).
  - Normal end: the accepted octet has last=1 -> IPG.
  - Oversize: the accepted octet is octet number MAX_FRAME with last=0 -> ERR.
  - Underrun: valid low at the edge -> ERR.
- ERR: exactly one cycle with TX_EN=1, TX_ER=1, tx_octet=0x00. ready is low. Then -> IPG. The source must discard the rest of its frame.
- IPG:
  - On entry: TX_EN<=0, TX_ER<=0, tx_octet<=0x00, both grants<=0, counter<=0, pointer<=served source.
  - Stays IPG_LEN-1 cycles, then -> IDLE. The IDLE arbitration cycle completes the IPG_LEN minimum gap, so back-to-back frames have exactly IPG_LEN TX_EN-low cycles.
- Grant holding: grant is held from the arbitration edge until IPG entry. req changes during that time are ignored. A requester that drops req before being granted is not served.
- TX_ER is high only in ERR.
- busy = (state != IDLE).

Test Plan:
1. Single frame, source A: 05 02 08 06 07 02 03 02 06 0A, last on 0A -> TX_EN high for 18 contiguous cycles (7x55, D5, 10 payload octets in order), TX_ER=0 throughout, then at least 12 cycles with TX_EN=0; grant_b stays 0.
2. Simultaneous req_a/req_b held high through four frames after reset -> served order A, B, A, B; each gap is exactly 12 TX_EN-low cycles.
3. Underrun: source A sends 05 02 08 06, then valid_a=0 -> the cycle after 06 shows TX_EN=1, TX_ER=1, tx_octet=00; ready_a is low; then 12 idle cycles and IDLE.
4. Oversize with MAX_FRAME=16: 20 octets with last never set -> 16 payload octets, then one ERR cycle (TX_EN=1, TX_ER=1, 00), then IPG; octets 17-20 are never accepted.
5. Reset mid-DATA: RESET=1 after the 3rd payload octet -> the next cycle shows TX_EN=0, TX_ER=0, grant_a=0, busy=0; after release with req_a and req_b both high, A is granted and a clean 0x55 preamble starts.
6. PREAMBLE_LEN=1, IPG_LEN=2 override -> frame shows 55, D5, payload; the gap between back-to-back frames is exactly 2 cycles.
